// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS integer register file slice.
// Holds the default widths, the hard-wired zero register index and the
// index/word typedefs used by the register file and its scoreboard.
package mips_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 5;
   localparam int NUM_REGS_DEF   = 2 ** ADDR_WIDTH_DEF;

   // Register 0 is hard-wired to zero and never has a producer in flight.
   localparam int REG_ZERO = 0;

   typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;
   typedef logic [DATA_WIDTH_DEF-1:0] word_t;

endpackage : mips_pkg

// File: rtl/mips_reg_scoreboard.sv
// Pending-write scoreboard for the MIPS register file.
// One bit per register: set when a producer issues from decode, cleared when
// that register is written back. A same-cycle issue to the index being
// written back wins, since the new producer supersedes the retiring one.
// Optional feature macro: WRITE_BYPASS_EN -- a writeback in the current cycle
// hides the pending bit of the register it retires (unless re-issued).
module mips_reg_scoreboard
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic                  issue_en,
   input  logic [ADDR_WIDTH-1:0] issue_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic                  pending_a,
   output logic                  pending_b
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   logic [NUM_REGS-1:0] pend_r;
   logic [NUM_REGS-1:0] pend_nxt_s;
   logic                pending_a_s;
   logic                pending_b_s;

`ifdef WRITE_BYPASS_EN
   // True when this cycle's writeback retires idx and no new producer claims it.
   function automatic logic bypass_clears(input logic                  we,
                                          input logic [ADDR_WIDTH-1:0] wa,
                                          input logic                  ie,
                                          input logic [ADDR_WIDTH-1:0] ia,
                                          input logic [ADDR_WIDTH-1:0] idx);
      logic hit_s;
      if (we && (wa == idx) && (wa != ZERO_IDX) && !(ie && (ia == idx))) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
      return hit_s;
   endfunction
`endif

   // Next-state of each pending bit: issue sets (and wins), writeback clears.
   always_comb begin
      pend_nxt_s = pend_r;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (issue_en && (issue_addr == ADDR_WIDTH'(i))) begin
            pend_nxt_s[i] = 1'b1;
         end else if (wr_en && (wr_addr == ADDR_WIDTH'(i))) begin
            pend_nxt_s[i] = 1'b0;
         end else begin
            pend_nxt_s[i] = pend_r[i];
         end
      end
      pend_nxt_s[REG_ZERO] = 1'b0;
   end

   // Pending bit array; reset clears every entry regardless of issue/writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_r <= {NUM_REGS{1'b0}};
      end else begin
         pend_r <= pend_nxt_s;
      end
   end

   // Per-port pending lookup; register 0 never reports pending.
   always_comb begin
      pending_a_s = 1'b0;
      pending_b_s = 1'b0;
      if (rd_addr_a != ZERO_IDX) begin
         pending_a_s = pend_r[rd_addr_a];
      end else begin
         pending_a_s = 1'b0;
      end
      if (rd_addr_b != ZERO_IDX) begin
         pending_b_s = pend_r[rd_addr_b];
      end else begin
         pending_b_s = 1'b0;
      end
`ifdef WRITE_BYPASS_EN
      if (bypass_clears(wr_en, wr_addr, issue_en, issue_addr, rd_addr_a)) begin
         pending_a_s = 1'b0;
      end else begin
         pending_a_s = pending_a_s;
      end
      if (bypass_clears(wr_en, wr_addr, issue_en, issue_addr, rd_addr_b)) begin
         pending_b_s = 1'b0;
      end else begin
         pending_b_s = pending_b_s;
      end
`endif
   end

   assign pending_a = pending_a_s;
   assign pending_b = pending_b_s;

endmodule : mips_reg_scoreboard

// File: rtl/mips_reg_file.sv
// MIPS integer register file with two combinational read ports (rs, rt),
// one writeback port and a pending-write scoreboard for decode stalls.
// Optional feature macro: WRITE_BYPASS_EN -- forwards the writeback value to a
// read port addressing the same register in the same cycle.
module mips_reg_file
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic [DATA_WIDTH-1:0] rd_data_b,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  issue_en,
   input  logic [ADDR_WIDTH-1:0] issue_addr,
   output logic                  pending_a,
   output logic                  pending_b,
   output logic                  stall
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
   logic [DATA_WIDTH-1:0] rd_data_a_s;
   logic [DATA_WIDTH-1:0] rd_data_b_s;
   logic                  pending_a_s;
   logic                  pending_b_s;

   // Data array: reset zeroes everything; writes to register 0 are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (wr_en && (wr_addr != ZERO_IDX)) begin
         regs_r[wr_addr] <= wr_data;
      end else begin
         regs_r[ZERO_IDX] <= {DATA_WIDTH{1'b0}};
      end
   end

   // Asynchronous read muxes, with same-cycle forwarding when bypass is built in.
   always_comb begin
      rd_data_a_s = regs_r[rd_addr_a];
      rd_data_b_s = regs_r[rd_addr_b];
`ifdef WRITE_BYPASS_EN
      if (wr_en && (wr_addr != ZERO_IDX) && (wr_addr == rd_addr_a)) begin
         rd_data_a_s = wr_data;
      end else begin
         rd_data_a_s = regs_r[rd_addr_a];
      end
      if (wr_en && (wr_addr != ZERO_IDX) && (wr_addr == rd_addr_b)) begin
         rd_data_b_s = wr_data;
      end else begin
         rd_data_b_s = regs_r[rd_addr_b];
      end
`endif
   end

   mips_reg_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .pending_a  (pending_a_s),
      .pending_b  (pending_b_s)
   );

   assign rd_data_a = rd_data_a_s;
   assign rd_data_b = rd_data_b_s;
   assign pending_a = pending_a_s;
   assign pending_b = pending_b_s;
   assign stall     = pending_a_s | pending_b_s;

endmodule : mips_reg_file

// File: tb/tb_mips_reg_file.sv
// Self-checking bench for mips_reg_file: directed scenarios followed by
// randomized traffic, checked by a scoreboard against an array-based model.
module tb_mips_reg_file;

   logic        clk;
   logic        rst;
   logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, issue_addr;
   logic [31:0] rd_data_a, rd_data_b, wr_data;
   logic        wr_en, issue_en;
   logic        pending_a, pending_b, stall;

   mips_reg_file dut (
      .clk        (clk),
      .rst        (rst),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .rd_data_a  (rd_data_a),
      .rd_data_b  (rd_data_b),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .pending_a  (pending_a),
      .pending_b  (pending_b),
      .stall      (stall)
   );

`ifdef WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        pa;
      logic        pb;
      logic        st;
      int          n;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int          step_no = 0;

   // reference model: architectural register values and outstanding producers
   logic [31:0] m_regs [32];
   bit          m_pend [32];

   function automatic logic [31:0] m_read(input logic [4:0] ra);
      if (ra == 5'd0) return 32'd0;
      if (BYP && wr_en && wr_addr == ra) return wr_data;
      return m_regs[ra];
   endfunction

   function automatic logic m_pending(input logic [4:0] ra);
      if (ra == 5'd0) return 1'b0;
      if (BYP && wr_en && wr_addr == ra && !(issue_en && issue_addr == ra)) return 1'b0;
      return m_pend[ra];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int n);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, n, act, exp);
      end
   endtask

   // one clock of stimulus: drive, record expectation, advance the model
   task automatic step(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit ie, input logic [4:0] ia, input logic [4:0] ra, input logic [4:0] rb);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
      issue_en = ie; issue_addr = ia; rd_addr_a = ra; rd_addr_b = rb;
      step_no++;
      e.a  = m_read(ra);
      e.b  = m_read(rb);
      e.pa = m_pending(ra);
      e.pb = m_pending(rb);
      e.st = e.pa | e.pb;
      e.n  = step_no;
      q.push_back(e);
      if (r) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
         end
      end else begin
         if (we && wa != 5'd0) begin
            m_regs[wa] = wd;
            m_pend[wa] = 1'b0;
         end
         if (ie && ia != 5'd0) m_pend[ia] = 1'b1;
      end
   endtask

   task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra, rb);
   endtask

   // monitor: outputs are combinational, so every cycle presents a response
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd_data_a", rd_data_a, e.a, e.n);
            chk("rd_data_b", rd_data_b, e.b, e.n);
            chk("pending_a", {31'd0, pending_a}, {31'd0, e.pa}, e.n);
            chk("pending_b", {31'd0, pending_b}, {31'd0, e.pb}, e.n);
            chk("stall", {31'd0, stall}, {31'd0, e.st}, e.n);
         end
      end
   end

   initial begin
      logic [4:0] wa, ia;
      int wait_cycles;
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 32'd0;
         m_pend[i] = 1'b0;
      end
      rst = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
      issue_en = 1'b0; issue_addr = 5'd0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset after random writes and issues clears everything
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step(1'b1, 1'b1, 5'd4, 32'hA5A5A5A5, 1'b1, 5'd6, 5'd4, 5'd6);
      for (int i = 0; i < 16; i++) idle(5'(2 * i), 5'(2 * i + 1));

      // plain write, visible next cycle (same cycle only with bypass)
      step(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 5'd8, 5'd8);
      idle(5'd8, 5'd0);

      // register 0 ignores writes and issues
      step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
      idle(5'd0, 5'd0);

      // issue then later writeback of register 5
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd1, 5'd5);
      idle(5'd1, 5'd5);
      idle(5'd5, 5'd5);
      step(1'b0, 1'b1, 5'd5, 32'h00000055, 1'b0, 5'd0, 5'd1, 5'd5);
      idle(5'd1, 5'd5);

      // same-edge issue and writeback of register 7: set wins
      step(1'b0, 1'b1, 5'd7, 32'h00001234, 1'b1, 5'd7, 5'd7, 5'd7);
      idle(5'd7, 5'd7);
      step(1'b0, 1'b1, 5'd7, 32'h00005678, 1'b0, 5'd0, 5'd7, 5'd7);
      idle(5'd7, 5'd2);

      // re-issue keeps the bit; first writeback clears it
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd0);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd0);
      step(1'b0, 1'b1, 5'd12, 32'h0000C0DE, 1'b0, 5'd0, 5'd12, 5'd0);
      idle(5'd12, 5'd0);

      // reset while 3 and 9 are pending and 3 is being written
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd9);
      step(1'b0, 1'b1, 5'd3, 32'h33333333, 1'b1, 5'd9, 5'd3, 5'd9);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd9);
      step(1'b1, 1'b1, 5'd3, 32'h77777777, 1'b1, 5'd9, 5'd3, 5'd9);
      idle(5'd3, 5'd9);

      // randomized traffic concentrated on a few registers to force collisions
      for (int i = 0; i < 3000; i++) begin
         wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         ia = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
              1'($urandom_range(0, 1)), ia, 5'($urandom_range(0, 8)), 5'($urandom_range(0, 31)));
      end

      // drain: bounded wait for the monitor to consume the last expectations
      wait_cycles = 0;
      while (q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mips_reg_file
